// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths and function-code constants for the ALU slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int SHAMT_W   = 5;

    typedef enum logic [3:0] {
        FN_ADD   = 4'd0,
        FN_SUB   = 4'd1,
        FN_AND   = 4'd2,
        FN_OR    = 4'd3,
        FN_XOR   = 4'd4,
        FN_NOR   = 4'd5,
        FN_NOT   = 4'd6,
        FN_SLL   = 4'd7,
        FN_SRL   = 4'd8,
        FN_SRA   = 4'd9,
        FN_SLLV  = 4'd10,
        FN_SRLV  = 4'd11,
        FN_SRAV  = 4'd12,
        FN_SLT   = 4'd13,
        FN_SLTU  = 4'd14,
        FN_PASSB = 4'd15
    } funct_e;

endpackage

`default_nettype wire

// File: rtl/alu_if.sv
// ============================================================================
// Module      : alu_if
// Description : Operand/result bundle between the capture front end and ALU.
//               Flag signals exist only when ALU_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    import alu_pkg::*;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic [3:0]         funct;
    logic [WIDTH-1:0]   res;
`ifdef ALU_FLAGS_EN
    logic               zero;
    logic               neg;
    logic               carry;
    logic               ovf;

    modport master (output a, b, shamt, funct, input  res, zero, neg, carry, ovf);
    modport slave  (input  a, b, shamt, funct, output res, zero, neg, carry, ovf);
`else
    modport master (output a, b, shamt, funct, input  res);
    modport slave  (input  a, b, shamt, funct, output res);
`endif

endinterface

`default_nettype wire

// File: rtl/alu_shifter.sv
// ============================================================================
// Module      : alu_shifter
// Description : Combinational logarithmic barrel shifter (dir=1 shifts left).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic [WIDTH-1:0]   data,
    input  wire logic [SHAMT_W-1:0] amount,
    input  wire logic               dir,
    input  wire logic               arith,
    output logic      [WIDTH-1:0]   result
);

    logic [WIDTH-1:0] w_stage [0:SHAMT_W];
    logic             w_fill;

    assign w_fill     = arith & data[WIDTH-1];
    assign w_stage[0] = data;

    // Stage k conditionally shifts by 2**k, selected by amount[k].
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        logic [WIDTH-1:0] w_left;
        logic [WIDTH-1:0] w_right;

        assign w_left         = {w_stage[k][WIDTH-1-SH:0], {SH{1'b0}}};
        assign w_right        = {{SH{w_fill}}, w_stage[k][WIDTH-1:SH]};
        assign w_stage[k+1]   = amount[k] ? (dir ? w_left : w_right) : w_stage[k];
    end

    assign result = w_stage[SHAMT_W];

endmodule

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : 32-bit signed ALU with registered result, one-cycle latency.
//               Define ALU_FLAGS_EN to add registered zero/neg/carry/ovf flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_if.slave      bus
);

    localparam int c_msb = WIDTH - 1;

    logic               w_sub;
    logic [WIDTH-1:0]   w_b_op;
    logic [WIDTH:0]     w_sum_full;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_ovf;
    logic               w_slt;
    logic               w_sltu;
    logic               w_var_shift;
    logic               w_left;
    logic               w_arith;
    logic [SHAMT_W-1:0] w_amount;
    logic [WIDTH-1:0]   w_shift;
    logic [WIDTH-1:0]   w_res_next;
    logic [WIDTH-1:0]   r_res;

    // One adder serves ADD, SUB and both compares: subtract = invert b, carry-in 1.
    assign w_sub      = (bus.funct != FN_ADD);
    assign w_b_op     = bus.b ^ {WIDTH{w_sub}};
    assign w_sum_full = {1'b0, bus.a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};
    assign w_sum      = w_sum_full[WIDTH-1:0];
    assign w_cout     = w_sum_full[WIDTH];
    assign w_ovf      = (bus.a[c_msb] == w_b_op[c_msb]) && (w_sum[c_msb] != bus.a[c_msb]);
    assign w_slt      = w_sum[c_msb] ^ w_ovf;
    assign w_sltu     = ~w_cout;

    assign w_var_shift = (bus.funct == FN_SLLV) || (bus.funct == FN_SRLV) || (bus.funct == FN_SRAV);
    assign w_left      = (bus.funct == FN_SLL)  || (bus.funct == FN_SLLV);
    assign w_arith     = (bus.funct == FN_SRA)  || (bus.funct == FN_SRAV);
    assign w_amount    = w_var_shift ? bus.b[SHAMT_W-1:0] : bus.shamt;

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .data   (bus.a),
        .amount (w_amount),
        .dir    (w_left),
        .arith  (w_arith),
        .result (w_shift)
    );

    always_comb begin
        w_res_next = '0;
        case (bus.funct)
            FN_ADD, FN_SUB:                   w_res_next = w_sum;
            FN_AND:                           w_res_next = bus.a & bus.b;
            FN_OR:                            w_res_next = bus.a | bus.b;
            FN_XOR:                           w_res_next = bus.a ^ bus.b;
            FN_NOR:                           w_res_next = ~(bus.a | bus.b);
            FN_NOT:                           w_res_next = ~bus.a;
            FN_SLL, FN_SRL, FN_SRA,
            FN_SLLV, FN_SRLV, FN_SRAV:        w_res_next = w_shift;
            FN_SLT:                           w_res_next = {{(WIDTH-1){1'b0}}, w_slt};
            FN_SLTU:                          w_res_next = {{(WIDTH-1){1'b0}}, w_sltu};
            FN_PASSB:                         w_res_next = bus.b;
            default:                          w_res_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
        end else begin
            r_res <= w_res_next;
        end
    end

    assign bus.res = r_res;

`ifdef ALU_FLAGS_EN
    logic w_is_addsub;
    logic r_zero;
    logic r_neg;
    logic r_carry;
    logic r_ovf;

    assign w_is_addsub = (bus.funct == FN_ADD) || (bus.funct == FN_SUB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_zero  <= (w_res_next == '0);
            r_neg   <= w_res_next[c_msb];
            r_carry <= w_is_addsub & w_cout;
            r_ovf   <= w_is_addsub & w_ovf;
        end
    end

    assign bus.zero  = r_zero;
    assign bus.neg   = r_neg;
    assign bus.carry = r_carry;
    assign bus.ovf   = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module      : tb_alu
// Description : Self-checking bench: directed literal cases plus randomized
//               stimulus compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference result straight from the operation definitions.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic [3:0] fn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (fn)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ~a;
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return sa >>> sh;
            4'd10:   return a << b[4:0];
            4'd11:   return a >> b[4:0];
            4'd12:   return sa >>> b[4:0];
            4'd13:   return (sa < sb) ? 32'd1 : 32'd0;
            4'd14:   return (a < b) ? 32'd1 : 32'd0;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Compare process: expectation captured at each rising edge, checked at the falling edge.
    logic [31:0] exp_res;
    logic        exp_valid = 1'b0;
`ifdef ALU_FLAGS_EN
    logic [3:0]  exp_flags;
`endif

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_res = '0;
            end else begin
                exp_res = model(bus.a, bus.b, bus.shamt, bus.funct);
            end
`ifdef ALU_FLAGS_EN
            begin
                logic [32:0] s;
                logic        c;
                logic        o;
                c = 1'b0;
                o = 1'b0;
                if (!rst && bus.funct == 4'd0) begin
                    s = {1'b0, bus.a} + {1'b0, bus.b};
                    c = s[32];
                    o = (bus.a[31] == bus.b[31]) && (exp_res[31] != bus.a[31]);
                end else if (!rst && bus.funct == 4'd1) begin
                    c = (bus.a >= bus.b);
                    o = (bus.a[31] != bus.b[31]) && (exp_res[31] != bus.a[31]);
                end
                exp_flags = rst ? 4'b0 : {exp_res == 32'd0, exp_res[31], c, o};
            end
`endif
            exp_valid = 1'b1;
            @(negedge clk);
            if (exp_valid) begin
                total++;
                if (bus.res !== exp_res) begin
                    bad++;
                    $display("FAIL model res fn=%0d: got %h want %h", bus.funct, bus.res, exp_res);
                end
`ifdef ALU_FLAGS_EN
                total++;
                if ({bus.zero, bus.neg, bus.carry, bus.ovf} !== exp_flags) begin
                    bad++;
                    $display("FAIL model flags: got %b want %b",
                             {bus.zero, bus.neg, bus.carry, bus.ovf}, exp_flags);
                end
`endif
            end
        end
    end

    // Directed step: drive at the falling edge, check the literal just after the next rising edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [3:0] fn, input logic r, input logic [31:0] want,
                        input string name);
        bus.a     = a;
        bus.b     = b;
        bus.shamt = sh;
        bus.funct = fn;
        rst       = r;
        @(posedge clk);
        #1;
        total++;
        if (bus.res !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, bus.res, want);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.a     = '0;
        bus.b     = '0;
        bus.shamt = '0;
        bus.funct = '0;
        @(negedge clk);
        @(negedge clk);

        step(32'd5, 32'd7, 5'd0, 4'd0, 1'b1, 32'd0, "reset");
        step(32'd5, 32'd7, 5'd0, 4'd0, 1'b0, 32'd12, "add after reset");
        step(32'h7FFF_FFFF, 32'd1, 5'd0, 4'd0, 1'b0, 32'h8000_0000, "add wrap");
`ifdef ALU_FLAGS_EN
        total++;
        if ({bus.neg, bus.ovf} !== 2'b11) begin
            bad++;
            $display("FAIL add wrap flags: got %b want 11", {bus.neg, bus.ovf});
        end
`endif
        step(32'd3, 32'd5, 5'd0, 4'd1, 1'b0, 32'hFFFF_FFFE, "sub wrap");
        step(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 4'd2, 1'b0, 32'h00F0_00F0, "and");
        step(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 4'd3, 1'b0, 32'hFFF0_FFF0, "or");
        step(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 4'd4, 1'b0, 32'hFF00_FF00, "xor");
        step(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 4'd5, 1'b0, 32'h000F_000F, "nor");
        step(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 4'd6, 1'b0, 32'h0F0F_0F0F, "not");
        step(32'h8000_0001, 32'd0, 5'd4, 4'd7, 1'b0, 32'h0000_0010, "sll");
        step(32'h8000_0001, 32'd0, 5'd4, 4'd8, 1'b0, 32'h0800_0000, "srl");
        step(32'h8000_0001, 32'd0, 5'd4, 4'd9, 1'b0, 32'hF800_0000, "sra");
        step(32'h8000_0001, 32'hFFFF_FF1F, 5'd0, 4'd12, 1'b0, 32'hFFFF_FFFF, "srav 31");
        step(32'h1234_5678, 32'hFFFF_FFE0, 5'd0, 4'd10, 1'b0, 32'h1234_5678, "sllv 0");
        step(32'h8000_0000, 32'd0, 5'd31, 4'd8, 1'b0, 32'h0000_0001, "srl 31");
        step(32'hFFFF_FFFF, 32'd1, 5'd0, 4'd13, 1'b0, 32'd1, "slt -1<1");
        step(32'hFFFF_FFFF, 32'd1, 5'd0, 4'd14, 1'b0, 32'd0, "sltu -1<1");
        step(32'h8000_0000, 32'd1, 5'd0, 4'd13, 1'b0, 32'd1, "slt min<1");
        step(32'd9, 32'd9, 5'd0, 4'd13, 1'b0, 32'd0, "slt equal");
        step(32'd10, 32'd4, 5'd0, 4'd0, 1'b0, 32'd14, "b2b add");
        step(32'd10, 32'd4, 5'd0, 4'd1, 1'b0, 32'd6, "b2b sub");
        step(32'd10, 32'd4, 5'd0, 4'd15, 1'b0, 32'd4, "b2b passb");

        for (int i = 0; i < 3000; i++) begin
            bus.a     = pick();
            bus.b     = pick();
            bus.shamt = 5'($urandom);
            bus.funct = 4'($urandom);
            rst       = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu.md
Name: alu

Overview:
- 32-bit signed integer ALU with a registered result. Operation selected by a 4-bit function code; shift amount supplied separately.
- Sits behind the board-level operand-capture front end, which loads a, b, shamt and funct over a 16-bit switch bus and reads res back in two 16-bit halves.
- Pure datapath: no handshake. Output is valid one clock after the inputs are stable.

Parameters:
- WIDTH, 32, operand and result width; the shift-amount width is log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- a  input  WIDTH  operand A, two's-complement signed.
- b  input  WIDTH  operand B, two's-complement signed.
- shamt  input  5  immediate shift amount, unsigned 0..31.
- funct  input  4  operation select.
- res  output  WIDTH  registered result, signed.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst=1 at a rising clk edge, res<=0. Reset takes priority over any operation.
- Latency: res is updated on every rising clk edge with the result of the inputs sampled at that edge (1-cycle latency, no enable). Inputs may change every cycle.
- Function codes (funct):
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOR
  - 6 NOT: ~a
  - 7 SLL: a<<shamt
  - 8 SRL: logical a>>shamt
  - 9 SRA: arithmetic a>>>shamt
  - 10 SLLV: a<<b[4:0]
  - 11 SRLV: a>>b[4:0]
  - 12 SRAV: a>>>b[4:0]
  - 13 SLT: signed (a<b) ? 1 : 0
  - 14 SLTU: unsigned (a<b) ? 1 : 0
  - 15 PASSB: b
- Arithmetic: add and sub wrap modulo 2^32. No saturation and no exceptions.
- SLT uses the true signed comparison (sign of a-b corrected for overflow). Example: a=0x80000000, b=1 gives 1.
- Shifts:
  - A shift of 0 returns a unchanged.
  - A shift of 31 is valid.
  - Variable shifts use only b[4:0]; upper bits of b are ignored.
  - SRA/SRAV replicate a[31].
- All funct values are defined; no X on res for any input.

Optional Feature:
- Macro ALU_FLAGS_EN. When defined, add registered outputs, updated on the same edge as res and cleared by rst:
  - zero (1): res_next==0
  - neg (1): res_next[31]
  - carry (1): carry-out of ADD, or borrow-free (a>=b unsigned) for SUB; 0 for other ops
  - ovf (1): signed overflow for ADD/SUB; 0 for other ops
- When not defined, these ports and their logic do not exist; res behaviour is identical in both builds.

Decomposition:
- Package alu_pkg: WIDTH default, SHAMT_W=5, and the funct enum constants (FN_ADD..FN_PASSB) listed above.
- One sub-module, alu_shifter: combinational barrel shifter.
  - Inputs: data, amount[4:0], dir (left/right), arith.
  - Shared by the immediate and variable shift ops. The amount is muxed between shamt and b[4:0] before the shifter.
- Everything else stays in alu: add/sub with a single adder using b inversion plus carry-in, logic ops, compare, output register.

Test Plan:
- Reset: drive rst=1 with a=5, b=7, funct=ADD -> res=0 after the edge. Release rst -> res=12 one cycle later.
- Arithmetic wrap:
  - ADD a=0x7FFFFFFF, b=1 -> res=0x80000000 (flags build: ovf=1, neg=1).
  - SUB a=3, b=5 -> res=0xFFFFFFFE.
- Logic: a=0xF0F0F0F0, b=0x0FF00FF0 -> AND=0x00F000F0, OR=0xFFF0FFF0, XOR=0xFF00FF00, NOR=0x000F000F, NOT=0x0F0F0F0F.
- Shifts: a=0x80000001, shamt=4 -> SLL=0x00000010, SRL=0x08000000, SRA=0xF8000000. SRAV with b=0xFFFFFF1F -> 0xFFFFFFFF.
- Compare: a=-1, b=1 -> SLT=1, SLTU=0. a=0x80000000, b=1 -> SLT=1. a=b=9 -> SLT=0.
- Back-to-back: change funct every cycle ADD, SUB, PASSB with a=10, b=4 -> res sequence 14, 6, 4, each appearing one cycle after its input.
